// File: rtl/avfs_freq_switcher.sv
// AVFS frequency switcher: debounces freq_sel, sequences the regulator handshake and
// produces a glitch-free clock-enable whose divisor changes only on period boundaries.
module avfs_freq_switcher #(
  parameter int         DEBOUNCE_CYC = 4,
  parameter int         SETTLE_CYC   = 8,
  parameter int         ACK_TIMEOUT  = 64,
  parameter logic [3:0] RESET_SEL    = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] freq_sel,
  output logic       clk_en,
  output logic [3:0] cur_sel,
  output logic       volt_valid,
  output logic [3:0] volt_code,
  input  logic       volt_ack,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEBOUNCE    = 3'd1,
    V_UP_REQ    = 3'd2,
    V_UP_SETTLE = 3'd3,
    APPLY       = 3'd4,
    V_DN_REQ    = 3'd5
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [3:0]    target_r;
  logic [DW-1:0] dcnt_r;
  logic [SW-1:0] scnt_r;
  logic [TW-1:0] tcnt_r;
  logic          apply_s;

  // The switch happens exactly on the edge where the divider reloads
  always_comb begin
    apply_s = 1'b0;
    if ((state_r == APPLY) && (cnt_r == 4'd0)) begin
      apply_s = 1'b1;
    end else begin
      apply_s = 1'b0;
    end
  end

  // Divider: reload value div-1 = 15-sel, i.e. the bitwise inverse of the setting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 4'd0;
      clk_en <= 1'b0;
    end else if (cnt_r == 4'd0) begin
      cnt_r  <= apply_s ? ~target_r : ~cur_sel;
      clk_en <= 1'b1;
    end else begin
      cnt_r  <= cnt_r - 4'd1;
      clk_en <= 1'b0;
    end
  end

  // Sequencing FSM; a timeout in the same cycle as err_clr leaves err set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cur_sel    <= RESET_SEL;
      target_r   <= 4'd0;
      dcnt_r     <= '0;
      scnt_r     <= '0;
      tcnt_r     <= '0;
      volt_valid <= 1'b0;
      volt_code  <= 4'd0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (freq_sel != cur_sel) begin
            target_r <= freq_sel;
            dcnt_r   <= DW'(1);
            state_r  <= DEBOUNCE;
            busy     <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (freq_sel == cur_sel) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (freq_sel != target_r) begin
            target_r <= freq_sel;
            dcnt_r   <= DW'(1);
          end else if (dcnt_r == DW'(DEBOUNCE_CYC)) begin
            if (target_r > cur_sel) begin
              state_r    <= V_UP_REQ;
              volt_valid <= 1'b1;
              volt_code  <= target_r;
              tcnt_r     <= '0;
            end else begin
              state_r <= APPLY;
            end
          end else begin
            dcnt_r <= dcnt_r + DW'(1);
          end
        end
        V_UP_REQ, V_DN_REQ: begin
          if (volt_ack && volt_valid) begin
            volt_valid <= 1'b0;
            if (state_r == V_UP_REQ) begin
              state_r <= V_UP_SETTLE;
              scnt_r  <= '0;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else if (tcnt_r == TW'(ACK_TIMEOUT - 1)) begin
            volt_valid <= 1'b0;
            err        <= 1'b1;
            state_r    <= IDLE;
            busy       <= 1'b0;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        V_UP_SETTLE: begin
          if (scnt_r == SW'(SETTLE_CYC - 1)) begin
            state_r <= APPLY;
          end else begin
            scnt_r <= scnt_r + SW'(1);
          end
        end
        APPLY: begin
          if (apply_s) begin
            cur_sel <= target_r;
            if (target_r < cur_sel) begin
              state_r    <= V_DN_REQ;
              volt_valid <= 1'b1;
              volt_code  <= target_r;
              tcnt_r     <= '0;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          volt_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avfs_freq_switcher.sv
// Scoreboard bench for avfs_freq_switcher: stimulus pushes expected events
// (voltage request, setting switch, error) and a monitor checks them as they appear.
module tb_avfs_freq_switcher;

  localparam int D = 4;
  localparam int S = 8;
  localparam int T = 64;
  localparam int K_REQ = 0;
  localparam int K_SEL = 1;
  localparam int K_ERR = 2;

  logic       clk, rst_n, clk_en, volt_valid, volt_ack, busy, err, err_clr;
  logic [3:0] freq_sel, cur_sel, volt_code;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         when;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_ack_edge = -1000;
  bit         ack_en = 1'b1;
  int         ack_delay = 2;
  logic [3:0] stim_sel = 4'd0;

  avfs_freq_switcher #(.DEBOUNCE_CYC(D), .SETTLE_CYC(S), .ACK_TIMEOUT(T), .RESET_SEL(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .freq_sel(freq_sel), .clk_en(clk_en), .cur_sel(cur_sel),
    .volt_valid(volt_valid), .volt_code(volt_code), .volt_ack(volt_ack), .busy(busy),
    .err(err), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [3:0] v, input int w);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.when = w;
    sb.push_back(e);
  endtask

  // Regulator model: acknowledges ack_delay cycles after seeing a request
  initial begin
    int wait_cnt = 0;
    volt_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (volt_ack) begin
        volt_ack = 1'b0;
      end else if (volt_valid && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          volt_ack      = 1'b1;
          last_ack_edge = cyc + 1;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every observable event
  initial begin
    ev_t        e;
    int         earliest;
    logic [3:0] prev_sel = 4'd0;
    logic [3:0] model_sel = 4'd0;
    logic [3:0] req_code = 4'd0;
    bit         prev_vv = 1'b0;
    bit         prev_err = 1'b0;
    bit         has_last = 1'b0;
    int         last_pulse = 0;
    int         exp_div = 16;
    int         last_sel_cyc = -1000;
    int         last_req_cyc = -1000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel  = 4'd0;
        model_sel = 4'd0;
        prev_vv   = 1'b0;
        prev_err  = 1'b0;
        has_last  = 1'b0;
      end else begin
        if (cur_sel != prev_sel) begin
          check(sb.size() != 0, "unexpected_sel", int'(cur_sel), -1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            earliest = (e.when < 0) ? (last_ack_edge + S + 1) : e.when;
            check(e.kind == K_SEL, "sel_order", K_SEL, e.kind);
            check(cur_sel == e.val, "sel_value", int'(cur_sel), int'(e.val));
            check(cyc >= earliest && (!has_last || last_pulse < earliest), "sel_timing", cyc, earliest);
            check(clk_en == 1'b1, "sel_on_boundary", int'(clk_en), 1);
            model_sel    = e.val;
            last_sel_cyc = cyc;
          end
          prev_sel = cur_sel;
        end
        if (volt_valid && !prev_vv) begin
          check(sb.size() != 0, "unexpected_req", int'(volt_code), -1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            earliest = (e.when < 0) ? last_sel_cyc : e.when;
            check(e.kind == K_REQ, "req_order", K_REQ, e.kind);
            check(volt_code == e.val, "req_code", int'(volt_code), int'(e.val));
            check(cyc == earliest, "req_timing", cyc, earliest);
            check(busy == 1'b1, "req_busy", int'(busy), 1);
            req_code     = e.val;
            last_req_cyc = cyc;
          end
        end
        if (volt_valid) begin
          check(volt_code == req_code, "req_code_stable", int'(volt_code), int'(req_code));
        end
        if (err && !prev_err) begin
          check(sb.size() != 0, "unexpected_err", int'(err), 0);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.kind == K_ERR, "err_order", K_ERR, e.kind);
            check(cyc == last_req_cyc + T, "err_timing", cyc, last_req_cyc + T);
            check(volt_valid == 1'b0, "err_drops_valid", int'(volt_valid), 0);
          end
        end
        if (clk_en) begin
          if (has_last) begin
            check(cyc - last_pulse == exp_div, "clk_en_period", cyc - last_pulse, exp_div);
          end
          exp_div    = 16 - int'(model_sel);
          last_pulse = cyc;
          has_last   = 1'b1;
        end
        prev_vv  = volt_valid;
        prev_err = err;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 600);
    check(!busy && sb.size() == 0, name, sb.size(), 0);
  endtask

  task automatic clear_err();
    check(err == 1'b1, "err_sticky", int'(err), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check(err == 1'b0, "err_clear", int'(err), 0);
  endtask

  // One setting change; pre_en first drives a short-lived different value
  task automatic run_change(input logic [3:0] nv, input bit tmo, input logic [3:0] pre, input bit pre_en);
    int         c;
    int         n = 0;
    logic [3:0] old = stim_sel;
    ack_en = !tmo;
    @(negedge clk);
    if (pre_en) begin
      freq_sel = pre;
      repeat (2) @(negedge clk);
    end
    freq_sel = nv;
    c = cyc;
    if (nv > old) begin
      push(K_REQ, nv, c + D + 1);
      if (tmo) push(K_ERR, nv, 0);
      else     push(K_SEL, nv, -1);
    end else begin
      push(K_SEL, nv, c + D + 2);
      push(K_REQ, nv, -1);
      if (tmo) push(K_ERR, nv, 0);
    end
    if (tmo) begin
      do begin
        @(negedge clk);
        n++;
      end while (!err && n < 400);
      check(err == 1'b1, "err_timeout_seen", int'(err), 1);
      if (nv > old) freq_sel = old;
    end
    wait_idle("change_done");
    if (tmo) clear_err();
    stim_sel = (tmo && nv > old) ? old : nv;
    check(cur_sel == stim_sel, "settled_sel", int'(cur_sel), int'(stim_sel));
    ack_en = 1'b1;
  endtask

  task automatic glitch(input logic [3:0] nv);
    int h = $urandom_range(1, D - 1);
    @(negedge clk);
    freq_sel = nv;
    repeat (h) @(negedge clk);
    freq_sel = stim_sel;
    repeat (8) @(negedge clk);
    check(busy == 1'b0, "glitch_idle", int'(busy), 0);
    check(cur_sel == stim_sel, "glitch_sel", int'(cur_sel), int'(stim_sel));
  endtask

  task automatic reset_mid_settle(input logic [3:0] nv);
    int c;
    int n = 0;
    @(negedge clk);
    freq_sel = nv;
    c = cyc;
    push(K_REQ, nv, c + D + 1);
    push(K_SEL, nv, -1);
    do begin
      @(negedge clk);
      n++;
    end while (!volt_valid && n < 100);
    do begin
      @(negedge clk);
      n++;
    end while (volt_valid && n < 200);
    repeat (3) @(negedge clk);
    check(busy == 1'b1, "busy_in_settle", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check(cur_sel == 4'd0, "rst_async_cur_sel", int'(cur_sel), 0);
    check(clk_en == 1'b0, "rst_async_clk_en", int'(clk_en), 0);
    check(volt_valid == 1'b0, "rst_async_volt_valid", int'(volt_valid), 0);
    check(volt_code == 4'd0, "rst_async_volt_code", int'(volt_code), 0);
    check(busy == 1'b0, "rst_async_busy", int'(busy), 0);
    check(err == 1'b0, "rst_async_err", int'(err), 0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    c = cyc;
    push(K_REQ, nv, c + D + 1);
    push(K_SEL, nv, -1);
    stim_sel = nv;
    wait_idle("reset_redebounce");
    check(cur_sel == nv, "reset_final_sel", int'(cur_sel), int'(nv));
  endtask

  function automatic logic [3:0] pick_other(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] v;
    do v = 4'($urandom_range(0, 15)); while (v == x || v == y);
    return v;
  endfunction

  initial begin
    logic [3:0] a, b;
    int         r;
    rst_n    = 1'b0;
    freq_sel = 4'd0;
    err_clr  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check(cur_sel == 4'd0, "reset_cur_sel", int'(cur_sel), 0);
    check(clk_en == 1'b0, "reset_clk_en", int'(clk_en), 0);
    check(volt_valid == 1'b0, "reset_volt_valid", int'(volt_valid), 0);
    check(busy == 1'b0, "reset_busy", int'(busy), 0);
    check(err == 1'b0, "reset_err", int'(err), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(clk_en == 1'b1, "first_pulse", int'(clk_en), 1);
    repeat (40) @(negedge clk);
    check(busy == 1'b0 && err == 1'b0, "t1_idle", int'({busy, err}), 0);

    ack_delay = 2;
    run_change(4'd15, 1'b0, 4'd0, 1'b0);
    repeat (6) @(negedge clk);
    ack_delay = 1;
    run_change(4'd8, 1'b0, 4'd0, 1'b0);
    repeat (20) @(negedge clk);
    glitch(4'd5);
    run_change(4'd12, 1'b1, 4'd0, 1'b0);
    repeat (5) @(negedge clk);
    reset_mid_settle(4'd14);
    run_change(4'd2, 1'b1, 4'd0, 1'b0);

    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 9);
      ack_delay = $urandom_range(0, 4);
      b = pick_other(stim_sel, stim_sel);
      if (r <= 5) begin
        run_change(b, 1'b0, 4'd0, 1'b0);
      end else if (r == 6) begin
        run_change(b, 1'b1, 4'd0, 1'b0);
      end else if (r <= 8) begin
        glitch(b);
      end else begin
        a = pick_other(stim_sel, b);
        run_change(b, 1'b0, a, 1'b1);
      end
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    wait_idle("final_idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
